// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic operand feed sequencer.
// Default array geometry lives here so the controller and its bench agree.
package systolic_pkg;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} feed_state_t;

  localparam int DEF_DIM       = 32;
  localparam int DEF_ARRAY_LAT = 32;

  function automatic int dim_width(input int dim);
    return $clog2(dim) + 1;
  endfunction

  function automatic int idx_width(input int dim);
    return $clog2(2 * dim - 1);
  endfunction

  // Counters must reach 2*DIM+ARRAY_LAT, hence the +1 before the log.
  function automatic int cnt_width(input int dim, input int lat);
    return $clog2(2 * dim + lat + 1);
  endfunction

  localparam int DEF_IDX_W = idx_width(DEF_DIM);
  localparam int DEF_CNT_W = cnt_width(DEF_DIM, DEF_ARRAY_LAT);

  // Cycles from the start pulse to the done pulse when the array never stalls.
  function automatic int nostall_latency(input int m, input int n, input int k, input int lat);
    return 1 + (m + n - 1) + (k + lat) + 1;
  endfunction

endpackage

// File: rtl/feed_down_counter.sv
// Loadable down counter with enable; o_tc flags when the count equals TC_VALUE.
// Counting stops at zero so a late enable can never wrap the value.
module feed_down_counter #(
  parameter int W        = 8,
  parameter int TC_VALUE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_loadVal,
  input  logic         i_en,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_tc = (r_count == W'(TC_VALUE));

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Streams skewed matrix-A wavefront columns into the systolic array, then drains it.
// Optional macro FEED_PERF_CNT_EN adds stall_cycles / run_cycles performance counters.
module systolic_feed_ctrl
  import systolic_pkg::*;
#(
  parameter int DIM       = DEF_DIM,
  parameter int ARRAY_LAT = DEF_ARRAY_LAT,
  parameter int IDXW      = $clog2(2 * DIM - 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [$clog2(DIM):0]  m,
  input  logic [$clog2(DIM):0]  n,
  input  logic [$clog2(DIM):0]  k,
  input  logic                  array_ready,
  output logic                  busy,
  output logic                  feed_valid,
  output logic [IDXW-1:0]       col_idx,
  output logic                  acc_clear,
  output logic                  result_valid,
  output logic                  done,
  output logic                  err
`ifdef FEED_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           run_cycles
`endif
);

  localparam int DW = dim_width(DIM);
  localparam int CW = cnt_width(DIM, ARRAY_LAT);

  feed_state_t r_state, w_nextState;

  logic [DW-1:0]   r_m, r_n, r_k;
  logic            r_err;
  logic [IDXW-1:0] r_colIdx;

  logic            w_dimsOk, w_accept;
  logic            w_beat, w_beatLast, w_beatLoad;
  logic            w_drainLoad, w_drainEn, w_drainZero;
  logic [DW:0]     w_mnMinus1;
  logic [CW-1:0]   w_beatInit, w_drainInit;

  assign w_dimsOk = (m != '0) && (m <= DW'(DIM)) &&
                    (n != '0) && (n <= DW'(DIM)) &&
                    (k != '0) && (k <= DW'(DIM));
  assign w_accept = (r_state == IDLE) && start && w_dimsOk;

  // One extra bit keeps m+n-1 exact before it is widened into the counter.
  assign w_mnMinus1  = {1'b0, r_m} + {1'b0, r_n} - (DW + 1)'(1);
  assign w_beatInit  = CW'(w_mnMinus1);
  assign w_drainInit = CW'(r_k) + CW'(ARRAY_LAT - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    busy         = 1'b1;
    feed_valid   = 1'b0;
    acc_clear    = 1'b0;
    result_valid = 1'b0;
    done         = 1'b0;
    w_beat       = 1'b0;
    w_beatLoad   = 1'b0;
    w_drainLoad  = 1'b0;
    w_drainEn    = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_accept) w_nextState = CLEAR;
      end
      CLEAR: begin
        acc_clear   = 1'b1;
        w_beatLoad  = 1'b1;
        w_nextState = FEED;
      end
      FEED: begin
        feed_valid = 1'b1;
        w_beat     = array_ready;
        if (array_ready && w_beatLast) begin
          w_drainLoad = 1'b1;
          w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        w_drainEn = 1'b1;
        if (w_drainZero) w_nextState = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        done         = 1'b1;
        w_nextState  = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m   <= '0;
      r_n   <= '0;
      r_k   <= '0;
      r_err <= 1'b0;
    end else if ((r_state == IDLE) && start) begin
      r_err <= !w_dimsOk;
      if (w_dimsOk) begin
        r_m <= m;
        r_n <= n;
        r_k <= k;
      end
    end
  end

  // The final beat leaves col_idx untouched so m+n-1 = 2*DIM-1 cannot wrap below 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_colIdx <= '0;
    end else if (w_beatLoad) begin
      r_colIdx <= IDXW'(2 * DIM - 2);
    end else if (w_beat && !w_beatLast) begin
      r_colIdx <= r_colIdx - IDXW'(1);
    end
  end

  feed_down_counter #(.W(CW), .TC_VALUE(1)) u_beatCnt (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_beatLoad),
    .i_loadVal (w_beatInit),
    .i_en      (w_beat),
    .o_tc      (w_beatLast)
  );

  feed_down_counter #(.W(CW), .TC_VALUE(0)) u_drainCnt (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_drainLoad),
    .i_loadVal (w_drainInit),
    .i_en      (w_drainEn),
    .o_tc      (w_drainZero)
  );

  assign col_idx = r_colIdx;
  assign err     = r_err;

`ifdef FEED_PERF_CNT_EN
  logic [31:0] r_stallCycles, r_runCycles;

  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_stallCycles <= '0;
      r_runCycles   <= '0;
    end else begin
      if (busy && (r_runCycles != '1)) r_runCycles <= r_runCycles + 32'd1;
      if ((r_state == FEED) && !array_ready && (r_stallCycles != '1))
        r_stallCycles <= r_stallCycles + 32'd1;
    end
  end

  assign stall_cycles = r_stallCycles;
  assign run_cycles   = r_runCycles;
`endif

endmodule
